// File: rtl/mult_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mult_rr_scheduler
//   Round-robin scheduler that shares one signed fixed-point multiplier
//   between N_REQ requesters. The winning operand pair is captured into
//   operand registers and drives the multiplier for one full settle cycle.
//   The scaled product is then returned on a single response channel,
//   tagged with the requester index, under valid/ready backpressure.
//
// Ports:
//   clk            clock
//   arst_n_in      asynchronous active-low reset (synchronous release)
//   req_valid_in   per-requester operand valid
//   req_ready_out  per-requester accept, one-hot on the winner or zero
//   req_a_in       packed operand A, requester i in slice i
//   req_b_in       packed operand B, requester i in slice i
//   rsp_valid_out  result valid
//   rsp_ready_in   result consumer ready
//   rsp_id_out     index of the requester owning the result
//   rsp_data_out   (a*b) >>> OUT_SCALE, truncated to OUT_WIDTH
//   grant_cnt_out  per-requester 16-bit saturating grant counters
//
// Optional feature: define MULT_SCHED_GRANT_CNT_EN to build the grant
// counters; otherwise grant_cnt_out is tied to zero.
// ---------------------------------------------------------------------------

// Shared multiplier: full signed product, arithmetic shift, truncation.
module mult_rr_scheduler_mul #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
    parameter int OUT_SCALE = 16
) (
    input  logic signed [A_WIDTH-1:0]   op_a,
    input  logic signed [B_WIDTH-1:0]   op_b,
    output logic signed [OUT_WIDTH-1:0] prod
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [P_WIDTH-1:0] full_s;
    logic signed [P_WIDTH-1:0] shifted_s;

    assign full_s    = P_WIDTH'(op_a) * P_WIDTH'(op_b);
    // Arithmetic shift floors toward minus infinity.
    assign shifted_s = full_s >>> OUT_SCALE;
    assign prod      = OUT_WIDTH'(shifted_s);
endmodule

module mult_rr_scheduler #(
    parameter int N_REQ     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = A_WIDTH + B_WIDTH,
    parameter int OUT_SCALE = 16,
    parameter int ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic [N_REQ-1:0]         req_valid_in,
    output logic [N_REQ-1:0]         req_ready_out,
    input  logic [N_REQ*A_WIDTH-1:0] req_a_in,
    input  logic [N_REQ*B_WIDTH-1:0] req_b_in,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [ID_WIDTH-1:0]      rsp_id_out,
    output logic [OUT_WIDTH-1:0]     rsp_data_out,
    output logic [N_REQ*16-1:0]      grant_cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [ID_WIDTH-1:0]          rr_ptr_r;
    logic [ID_WIDTH-1:0]          id_r;
    logic signed [A_WIDTH-1:0]    op_a_r;
    logic signed [B_WIDTH-1:0]    op_b_r;
    logic                         rsp_valid_r;
    logic [ID_WIDTH-1:0]          rsp_id_r;
    logic [OUT_WIDTH-1:0]         rsp_data_r;

    logic                         win_valid_s;
    logic [ID_WIDTH-1:0]          win_idx_s;
    logic [ID_WIDTH:0]            cand_s;
    logic [A_WIDTH-1:0]           sel_a_s;
    logic [B_WIDTH-1:0]           sel_b_s;
    logic                         can_accept_s;
    logic                         transfer_s;
    logic signed [OUT_WIDTH-1:0]  prod_s;

    // Single multiplier, fed only from the operand registers.
    mult_rr_scheduler_mul #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .OUT_SCALE(OUT_SCALE)
    ) u_mul (
        .op_a(op_a_r),
        .op_b(op_b_r),
        .prod(prod_s)
    );

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_WIDTH+1)'(k);
            if (cand_s >= (ID_WIDTH+1)'(N_REQ)) begin
                cand_s = cand_s - (ID_WIDTH+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_valid_s && req_valid_in[cand_s[ID_WIDTH-1:0]]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s[ID_WIDTH-1:0];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_WIDTH'(i) == win_idx_s) begin
                sel_a_s = req_a_in[i*A_WIDTH +: A_WIDTH];
                sel_b_s = req_b_in[i*B_WIDTH +: B_WIDTH];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Next-state logic and accept window; reset gates the ready path so
    // nothing is granted while the block is held in reset.
    always_comb begin
        state_nxt_s  = state_r;
        can_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                can_accept_s = arst_n_in;
                if (win_valid_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                can_accept_s = arst_n_in & rsp_ready_in;
                if (!rsp_ready_in) begin
                    state_nxt_s = ST_RESP;
                end else if (win_valid_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign transfer_s = can_accept_s & win_valid_s;

    // One-hot ready on the winner while an accept is possible.
    always_comb begin
        if (transfer_s) begin
            req_ready_out = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            req_ready_out = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, priority pointer and response registers.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            op_a_r      <= '0;
            op_b_r      <= '0;
            id_r        <= '0;
            rr_ptr_r    <= ID_WIDTH'(N_REQ - 1);
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else begin
            if (transfer_s) begin
                op_a_r   <= sel_a_s;
                op_b_r   <= sel_b_s;
                id_r     <= win_idx_s;
                rr_ptr_r <= win_idx_s;
            end
            if (state_r == ST_SETTLE) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= id_r;
                rsp_data_r  <= prod_s;
            end else if ((state_r == ST_RESP) && rsp_ready_in) begin
                // Drops for the settle cycle when a new request is taken.
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign rsp_valid_out = rsp_valid_r;
    assign rsp_id_out    = rsp_id_r;
    assign rsp_data_out  = rsp_data_r;

`ifdef MULT_SCHED_GRANT_CNT_EN
    logic [15:0] cnt_r [N_REQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (transfer_s && (win_idx_s == ID_WIDTH'(i)) &&
                    (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    // Pack counters onto the output bus.
    always_comb begin
        grant_cnt_out = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt_out[i*16 +: 16] = cnt_r[i];
        end
    end
`else
    assign grant_cnt_out = '0;
`endif

endmodule
